// File: rtl/i2s_capture_ctrl.sv
// -----------------------------------------------------------------------------
// i2s_capture_ctrl
//
// Masters the microphone I2S link and fills the FFT input frame buffer.
// A free-running divider produces bck_o / lrck_o from reset release onward.
// Once per frame a capture strobe fires two BCK periods into the right
// half-frame. When capturing, the strobe writes the receiver's left-channel word
// into the frame buffer. After FFT_N samples the frame is handed to the FFT
// through a ready/start handshake. The block then either stops (one-shot) or
// resumes capture at address 0 (continuous).
//
// Ports
//   clk_i        system clock
//   rst_i        synchronous, active-high reset
//   start_i      1-cycle request to begin capture (ignored unless idle)
//   cont_i       1 = restart capture after each handoff (sampled at handoff)
//   bck_o        I2S bit clock
//   lrck_o       I2S word select, 0 = left half-frame
//   sample_i     left-channel word from the I2S receiver
//   wr_en_o      frame buffer write strobe
//   wr_addr_o    frame buffer write address
//   wr_data_o    frame buffer write data
//   fft_ready_i  FFT can accept a new frame
//   fft_start_o  1-cycle pulse: frame buffer complete
//   busy_o       controller not idle
//   done_o       1-cycle pulse, coincident with fft_start_o
//   overrun_o    sticky: a sample was dropped while waiting in handoff
//
// Build option
//   I2S_WARMUP_EN  when defined, SYNC discards WARMUP_FRAMES whole frames
//                  after start_i before capture begins (mic power-up).
// -----------------------------------------------------------------------------
module i2s_capture_ctrl #(
  parameter int CLK_DIV       = 4,
  parameter int FRAME_RES     = 32,
  parameter int DATA_RES      = 24,
  parameter int FFT_N         = 256,
  parameter int ADDR_W        = 8,
  parameter int WARMUP_FRAMES = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                cont_i,
  output logic                bck_o,
  output logic                lrck_o,
  input  logic [DATA_RES-1:0] sample_i,
  output logic                wr_en_o,
  output logic [ADDR_W-1:0]   wr_addr_o,
  output logic [DATA_RES-1:0] wr_data_o,
  input  logic                fft_ready_i,
  output logic                fft_start_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                overrun_o
);

`ifdef I2S_WARMUP_EN
  localparam int WARM_LIMIT = WARMUP_FRAMES;
`else
  // Warm-up disabled: SYNC leaves on the first frame boundary.
  localparam int WARM_LIMIT = 0 * WARMUP_FRAMES;
`endif

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int BIT_W  = $clog2(2 * FRAME_RES);
  localparam int WARM_W = (WARM_LIMIT > 0) ? $clog2(WARM_LIMIT + 1) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(2 * FRAME_RES - 1);
  localparam logic [BIT_W-1:0]  BIT_HALF  = BIT_W'(FRAME_RES);
  // Value of bit_cnt just before the falling edge that makes it FRAME_RES+2.
  localparam logic [BIT_W-1:0]  CAP_PRE   = BIT_W'(FRAME_RES + 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FFT_N - 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARM_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_CAPTURE,
    S_HANDOFF
  } state_e;

  // ---------------------------------------------------------------------------
  // I2S clock generation (free running, independent of the FSM)
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             bck_q, bck_d;
  logic             lrck_q, lrck_d;
  logic             div_tc;
  logic             bck_fall;
  logic             frame_wrap;
  logic             cap;

  assign div_tc     = (div_cnt_q == DIV_LAST);
  assign bck_fall   = div_tc & bck_q;
  assign frame_wrap = bck_fall & (bit_cnt_q == BIT_LAST);
  // Fires on the clk edge that moves bit_cnt to FRAME_RES+2, giving the
  // receiver two BCK periods to settle its left-channel word.
  assign cap        = bck_fall & (bit_cnt_q == CAP_PRE);

  // NOTE: every signal written in an always_comb block gets a default at the
  // top, so no path can leave it unassigned and infer a latch.
  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    bck_d     = bck_q;
    bit_cnt_d = bit_cnt_q;
    if (div_tc) begin
      div_cnt_d = '0;
      bck_d     = ~bck_q;
    end
    if (bck_fall) begin
      bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
    end
    // Derived from the next bit count so lrck changes on the same edge.
    lrck_d = (bit_cnt_d >= BIT_HALF);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      bck_q     <= 1'b0;
      lrck_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bck_q     <= bck_d;
      lrck_q    <= lrck_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WARM_W-1:0]   warm_cnt_q, warm_cnt_d;
  logic                overrun_q, overrun_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_RES-1:0] wr_data_q, wr_data_d;
  logic                fft_start_q, fft_start_d;
  logic                busy_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    warm_cnt_d  = warm_cnt_q;
    overrun_d   = overrun_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    fft_start_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d    = S_SYNC;
          overrun_d  = 1'b0;
          addr_d     = '0;
          warm_cnt_d = '0;
        end
      end

      S_SYNC: begin
        // The first wrap aligns to a frame boundary; any further wraps
        // counted here are discarded warm-up frames.
        if (frame_wrap) begin
          if (warm_cnt_q == WARM_LAST) begin
            state_d = S_CAPTURE;
          end else begin
            warm_cnt_d = warm_cnt_q + 1'b1;
          end
        end
      end

      S_CAPTURE: begin
        if (cap) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = sample_i;
          addr_d    = addr_q + 1'b1;
          if (addr_q == ADDR_LAST) begin
            state_d = S_HANDOFF;
          end
        end
      end

      S_HANDOFF: begin
        // No buffer slot is free until the FFT takes the frame, so a sample
        // arriving now is lost.
        if (cap) begin
          overrun_d = 1'b1;
        end
        if (fft_ready_i) begin
          fft_start_d = 1'b1;
          addr_d      = '0;
          state_d     = cont_i ? S_CAPTURE : S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      warm_cnt_q  <= '0;
      overrun_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      fft_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      warm_cnt_q  <= warm_cnt_d;
      overrun_q   <= overrun_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      fft_start_q <= fft_start_d;
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign bck_o       = bck_q;
  assign lrck_o      = lrck_q;
  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign fft_start_o = fft_start_q;
  assign done_o      = fft_start_q;
  assign busy_o      = busy_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_i2s_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_i2s_capture_ctrl
//
// Self-checking bench for i2s_capture_ctrl. Expected behaviour comes from an
// arithmetic timeline model. The bench counts clk edges since reset release.
// The I2S clocks, frame boundaries, capture instants and handshake times are
// all computed from that count. A mock receiver presents a fresh random word
// for every frame, and every write is checked against the word of its frame.
// -----------------------------------------------------------------------------
module tb_i2s_capture_ctrl;

  localparam int CLK_DIV       = 2;
  localparam int FRAME_RES     = 32;
  localparam int DATA_RES      = 24;
  localparam int FFT_N         = 8;
  localparam int ADDR_W        = 3;
  localparam int WARMUP_FRAMES = 3;

`ifdef I2S_WARMUP_EN
  localparam int EXP_WARM = WARMUP_FRAMES;
`else
  localparam int EXP_WARM = 0;
`endif

  localparam int BCK_CLKS   = 2 * CLK_DIV;                 // clks per BCK period
  localparam int FRAME_CLKS = BCK_CLKS * 2 * FRAME_RES;    // clks per lrck frame
  localparam int CAP_OFS    = BCK_CLKS * (FRAME_RES + 2);  // capture phase in frame
  localparam int FRAME_WAIT = (EXP_WARM + FFT_N + 3) * FRAME_CLKS;

  logic                clk;
  logic                rst_i;
  logic                start_i;
  logic                cont_i;
  logic                bck_o;
  logic                lrck_o;
  logic [DATA_RES-1:0] sample_i;
  logic                wr_en_o;
  logic [ADDR_W-1:0]   wr_addr_o;
  logic [DATA_RES-1:0] wr_data_o;
  logic                fft_ready_i;
  logic                fft_start_o;
  logic                busy_o;
  logic                done_o;
  logic                overrun_o;

  i2s_capture_ctrl #(
    .CLK_DIV      (CLK_DIV),
    .FRAME_RES    (FRAME_RES),
    .DATA_RES     (DATA_RES),
    .FFT_N        (FFT_N),
    .ADDR_W       (ADDR_W),
    .WARMUP_FRAMES(WARMUP_FRAMES)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .cont_i     (cont_i),
    .bck_o      (bck_o),
    .lrck_o     (lrck_o),
    .sample_i   (sample_i),
    .wr_en_o    (wr_en_o),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o),
    .fft_ready_i(fft_ready_i),
    .fft_start_o(fft_start_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .overrun_o  (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release: after edge n the model state is a function of n.
  int edge_n = 0;
  always @(posedge clk) edge_n <= rst_i ? 0 : edge_n + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int n;
    int addr;
    int data;
  } wr_rec_t;

  wr_rec_t             wr_q[$];
  int                  start_q[$];
  logic [DATA_RES-1:0] fval[int];   // receiver word for each frame index

  task automatic check(input string tag, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: observed %0d, required %0d (t=%0t)", tag, act, req, $time);
  endtask

  // Timeline model of the I2S clocks.
  function automatic int exp_bck(input int n);
    return (n / CLK_DIV) % 2;
  endfunction

  function automatic int exp_bit(input int n);
    return (n / BCK_CLKS) % (2 * FRAME_RES);
  endfunction

  function automatic int exp_lrck(input int n);
    return (exp_bit(n) >= FRAME_RES) ? 1 : 0;
  endfunction

  // Edge of the first write when start_i was sampled on edge s. It falls in
  // the frame after the next boundary, plus any warm-up frames.
  function automatic int exp_first(input int s);
    return ((s / FRAME_CLKS) + 1 + EXP_WARM) * FRAME_CLKS + CAP_OFS;
  endfunction

  // Mock receiver: one random word per frame, stable for the whole frame.
  initial begin
    int f;
    sample_i = '0;
    forever begin
      @(negedge clk);
      f = edge_n / FRAME_CLKS;
      if (!fval.exists(f)) fval[f] = DATA_RES'($urandom);
      sample_i = fval[f];
    end
  end

  // Monitor: clocks every cycle, and writes/handshake events into queues.
  initial begin
    int f;
    forever begin
      @(negedge clk);
      check("bck", bck_o, exp_bck(edge_n));
      check("lrck", lrck_o, exp_lrck(edge_n));
      if (wr_en_o) begin
        f = edge_n / FRAME_CLKS;
        check("wr_phase", edge_n % FRAME_CLKS, CAP_OFS);
        check("wr_data_src", fval.exists(f), 1);
        if (fval.exists(f)) check("wr_data", wr_data_o, fval[f]);
        wr_q.push_back('{n: edge_n, addr: int'(wr_addr_o), data: int'(wr_data_o)});
      end
      if (fft_start_o || done_o) begin
        check("start_done_pair", {fft_start_o, done_o}, 2'b11);
        start_q.push_back(edge_n);
      end
    end
  end

  task automatic do_reset(input int cycles);
    rst_i = 1'b1;
    repeat (cycles) @(negedge clk);
    #1;
    check("rst_wr_en", wr_en_o, 0);
    check("rst_wr_addr", wr_addr_o, 0);
    check("rst_wr_data", wr_data_o, 0);
    check("rst_fft_start", fft_start_o, 0);
    check("rst_done", done_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_overrun", overrun_o, 0);
    check("rst_bck", bck_o, 0);
    check("rst_lrck", lrck_o, 0);
    rst_i = 1'b0;
    wr_q.delete();
    start_q.delete();
    fval.delete();
  endtask

  task automatic pulse_start(output int s);
    @(negedge clk);
    #1;
    start_i = 1'b1;
    s = edge_n + 1;
    @(negedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
    #1;
  endtask

  task automatic wait_writes(input int cnt, input int budget);
    int k = 0;
    while (wr_q.size() < cnt && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("wait_writes", (wr_q.size() >= cnt) ? 1 : 0, 1);
  endtask

  task automatic wait_starts(input int cnt, input int budget);
    int k = 0;
    while (start_q.size() < cnt && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("wait_starts", (start_q.size() >= cnt) ? 1 : 0, 1);
  endtask

  // Writes must be back to back, one per frame, with addresses cycling 0..FFT_N-1.
  task automatic check_writes(input int first, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      if (k < wr_q.size()) begin
        check("wr_addr", wr_q[k].addr, k % FFT_N);
        check("wr_time", wr_q[k].n, first + k * FRAME_CLKS);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int first;
    int last;
    int m;
    int ov_n;

    rst_i       = 1'b1;
    start_i     = 1'b0;
    cont_i      = 1'b0;
    fft_ready_i = 1'b0;

    // 1: free-running clocks while idle, no activity on the buffer side.
    do_reset(3);
    idle(600);
    check("idle_writes", wr_q.size(), 0);
    check("idle_starts", start_q.size(), 0);
    check("idle_busy", busy_o, 0);

    // 2: one-shot frame with the FFT always ready.
    fft_ready_i = 1'b1;
    pulse_start(s);
    check("s2_busy", busy_o, 1);
    first = exp_first(s);
    wait_starts(1, FRAME_WAIT);
    check("s2_nwrites", wr_q.size(), FFT_N);
    check_writes(first, FFT_N);
    if (start_q.size() > 0)
      check("s2_start_time", start_q[0], first + (FFT_N - 1) * FRAME_CLKS + 1);
    idle(3);
    check("s2_nstarts", start_q.size(), 1);
    check("s2_busy_end", busy_o, 0);
    check("s2_overrun", overrun_o, 0);

    // 3: FFT stalls after the frame fills; the next cap overruns.
    wr_q.delete();
    start_q.delete();
    fft_ready_i = 1'b0;
    pulse_start(s);
    first = exp_first(s);
    last  = first + (FFT_N - 1) * FRAME_CLKS;
    wait_writes(FFT_N, FRAME_WAIT);
    ov_n = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      #1;
      if (overrun_o && ov_n < 0) ov_n = edge_n;
    end
    check("s3_overrun_time", ov_n, last + FRAME_CLKS);
    check("s3_stall_starts", start_q.size(), 0);
    check("s3_stall_writes", wr_q.size(), FFT_N);
    check("s3_busy", busy_o, 1);
    fft_ready_i = 1'b1;
    m = edge_n + 1;
    wait_starts(1, 10);
    if (start_q.size() > 0) check("s3_start_time", start_q[0], m);
    idle(3);
    check("s3_busy_end", busy_o, 0);
    check("s3_overrun_sticky", overrun_o, 1);
    check_writes(first, FFT_N);

    // 4: continuous mode, two back-to-back frames; cont_i dropped mid frame 2.
    wr_q.delete();
    start_q.delete();
    cont_i = 1'b1;
    pulse_start(s);
    check("s4_overrun_clear", overrun_o, 0);
    first = exp_first(s);
    wait_writes(FFT_N + 2, FRAME_WAIT);
    cont_i = 1'b0;
    wait_starts(2, FRAME_WAIT);
    idle(FRAME_CLKS + 10);
    check("s4_nwrites", wr_q.size(), 2 * FFT_N);
    check_writes(first, 2 * FFT_N);
    check("s4_nstarts", start_q.size(), 2);
    for (int j = 0; j < 2; j++) begin
      if (j < start_q.size())
        check("s4_start_time", start_q[j], first + ((j + 1) * FFT_N - 1) * FRAME_CLKS + 1);
    end
    check("s4_overrun", overrun_o, 0);
    check("s4_busy_end", busy_o, 0);

    // 5: reset at the 4th write aborts; a new start begins again at address 0.
    wr_q.delete();
    start_q.delete();
    pulse_start(s);
    wait_writes(4, FRAME_WAIT);
    do_reset(1);
    idle(600);
    check("s5_no_writes", wr_q.size(), 0);
    check("s5_busy", busy_o, 0);
    pulse_start(s);
    first = exp_first(s);
    wait_writes(1, FRAME_WAIT);
    check_writes(first, 1);
    wait_starts(1, FRAME_WAIT);
    check("s5_nwrites", wr_q.size(), FFT_N);
    check_writes(first, FFT_N);
    idle(3);
    check("s5_busy_end", busy_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2s_capture_ctrl.md
Name: i2s_capture_ctrl

Overview:
Single-clock controller that masters the microphone I2S link and fills the FFT input buffer. It generates the bck and lrck clocks for the mic and for the I2S receiver, and latches the receiver's left-channel sample once per frame. It writes FFT_N consecutive samples into the FFT frame buffer, then hands the frame to the FFT with a ready/start handshake, in one-shot or continuous mode.

Parameters:
CLK_DIV, 4, system clock cycles per BCK half-period (must be ≥2)
FRAME_RES, 32, BCK periods per channel half-frame
DATA_RES, 24, sample width from the I2S receiver
FFT_N, 256, samples per FFT frame (power of two)
ADDR_W, 8, log2(FFT_N)
WARMUP_FRAMES, 16, frames discarded after start (used only with I2S_WARMUP_EN)

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset; synchronous, active-high
start_i  in  1  1-cycle request to begin capture
cont_i  in  1  1 = restart capture automatically after each handoff
bck_o  out  1  I2S bit clock to mic and receiver
lrck_o  out  1  I2S word select; 0 = left half-frame
sample_i  in  DATA_RES  left-channel word from the I2S receiver
wr_en_o  out  1  frame buffer write strobe
wr_addr_o  out  ADDR_W  frame buffer write address
wr_data_o  out  DATA_RES  frame buffer write data
fft_ready_i  in  1  FFT can accept a new frame
fft_start_o  out  1  1-cycle pulse: frame buffer complete
busy_o  out  1  state is not IDLE
done_o  out  1  1-cycle pulse, coincident with fft_start_o
overrun_o  out  1  sticky; a sample was dropped during HANDOFF

Behaviour:
- Reset: all outputs 0; div_cnt = 0, bit_cnt = 0; state IDLE; overrun cleared. rst_i asserted mid-capture aborts immediately, with no further writes.
- Clock generation runs freely from reset release, independent of state, so the mic stays clocked.
  - div_cnt counts 0..CLK_DIV-1; at terminal count bck_o toggles.
  - On each bck_o 1→0 edge, bit_cnt increments modulo 2*FRAME_RES.
  - lrck_o = 1 when bit_cnt ≥ FRAME_RES, else 0. It is registered and updates on the same clk edge as bit_cnt.
- Capture strobe (cap): asserted for one clk cycle on the bck_o falling edge that sets bit_cnt = FRAME_RES+2. This gives the receiver two BCK periods to settle left_o. There is exactly one cap per frame.
- States:
  - IDLE: start_i → SYNC; clear overrun_o and set wr_addr = 0.
  - SYNC: wait for bit_cnt to wrap to 0 → CAPTURE. With the warm-up feature, also discard frames as described under Optional Feature.
  - CAPTURE: on cap, drive wr_en_o = 1 for one cycle with wr_data_o = sample_i and wr_addr_o = current address, then increment the address. A write at address FFT_N-1 → HANDOFF, and the address wraps to 0.
  - HANDOFF: wait for fft_ready_i. In the first cycle it is high, pulse fft_start_o and done_o. Then go to CAPTURE (address 0, no re-SYNC) if cont_i = 1, else IDLE.
- A cap occurring in HANDOFF is dropped and sets overrun_o.
- Write latency: wr_en_o is asserted in the clk cycle immediately after cap.
- start_i is ignored when not in IDLE.
- cont_i is sampled only at handoff. Deasserting it mid-frame lets the current frame finish.
- busy_o = (state != IDLE), registered.

Optional Feature:
I2S_WARMUP_EN
- Defined: SYNC counts WARMUP_FRAMES complete frames (bit_cnt wraps) after start_i before entering CAPTURE, covering mic power-up output. WARMUP_FRAMES = 0 behaves as if the macro were undefined.
- Undefined: SYNC exits at the first bit_cnt wrap; the WARMUP_FRAMES parameter is unused.

Test Plan:
Use CLK_DIV=2, FRAME_RES=32, FFT_N=8 for all scenarios.
1. Reset, then idle 600 clks → bck_o period is 4 clks and lrck_o period is 256 clks, with 50% duty; wr_en_o, fft_start_o, busy_o and done_o stay 0.
2. Mock receiver drives sample_i = frame index (0x000001, 0x000002, …); pulse start_i, fft_ready_i = 1 → 8 writes, at addresses 0..7 with ascending data and one write per 256 clks. Then one fft_start_o/done_o pulse in the cycle after the address-7 write; state returns to IDLE and busy_o = 0.
3. Same as scenario 2 with fft_ready_i held 0 for 600 clks after the last write → fft_start_o waits for fft_ready_i; overrun_o = 1 after the first cap in HANDOFF; no write occurs to address 0 during the stall.
4. cont_i = 1 and fft_ready_i = 1 → back-to-back frames; the second frame writes start at address 0 on the next cap, with no gap frame; overrun_o stays 0.
5. Assert rst_i for 1 clk at the 4th write → no further wr_en_o, all outputs 0; a new start_i restarts at address 0 after the next frame boundary.
6. With I2S_WARMUP_EN and WARMUP_FRAMES = 3 → the first write occurs on the cap of the 4th frame after the boundary following start_i; repeat with the macro undefined → first write on the 1st frame.
